// File: rtl/digit_scan_mux.sv
// rtl/digit_scan_mux.sv - time-multiplexed seven-segment digit scanner with per-frame snapshot
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, leading-zero positions (never digit 0) are dark.
module digit_scan_mux #(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = 4,
  parameter int PRESCALE = 100000,
  localparam int SEL_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [N_DIGITS-1:0]         digit_en,
  output logic [DIGIT_W-1:0]          digit_out,
  output logic [SEL_W-1:0]            sel_out,
  output logic [N_DIGITS-1:0]         an_n,
  output logic                        blank,
  output logic                        frame_start
);

  localparam int PCNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0]  IDX_MAX  = SEL_W'(N_DIGITS - 1);

  logic [PCNT_W-1:0]           pcnt_q, pcnt_d;
  logic [SEL_W-1:0]            idx_q, idx_d;
  logic [N_DIGITS*DIGIT_W-1:0] snap_d_q, snap_d_d;
  logic [N_DIGITS-1:0]         snap_en_q, snap_en_d;
  logic                        primed_q, primed_d;

  logic [DIGIT_W-1:0]  digit_out_q, digit_out_d;
  logic [SEL_W-1:0]    sel_out_q, sel_out_d;
  logic [N_DIGITS-1:0] an_n_q, an_n_d;
  logic                blank_q, blank_d;
  logic                frame_start_q, frame_start_d;

  logic [N_DIGITS-1:0] dark;
  logic [DIGIT_W-1:0]  cur_digit;
  logic                cur_dark;

  // Prescaler, scan index and snapshot sequencing; snapshot is only refreshed at frame boundaries
  always_comb begin
    pcnt_d    = pcnt_q;
    idx_d     = idx_q;
    snap_d_d  = snap_d_q;
    snap_en_d = snap_en_q;
    primed_d  = primed_q;
    if (!primed_q) begin
      primed_d  = 1'b1;
      pcnt_d    = '0;
      idx_d     = '0;
      snap_d_d  = digits_in;
      snap_en_d = digit_en;
    end else if (pcnt_q == PCNT_MAX) begin
      pcnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d     = '0;
        snap_d_d  = digits_in;
        snap_en_d = digit_en;
      end else begin
        idx_d = idx_q + SEL_W'(1);
      end
    end else begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;

  // A position is dark when disabled, or when it and every higher position hold zero
  always_comb begin
    dark     = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (snap_d_q[i*DIGIT_W +: DIGIT_W] == '0);
      dark[i]  = !snap_en_q[i] || zero_run;
    end
    dark[0] = !snap_en_q[0];
  end
`else
  // Only the per-position enable darkens a digit; zeros are displayed
  always_comb begin
    dark = ~snap_en_q;
  end
`endif

  // Next output values from the current index and snapshot
  always_comb begin
    cur_digit = '0;
    cur_dark  = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == SEL_W'(i)) begin
        cur_digit = snap_d_q[i*DIGIT_W +: DIGIT_W];
        cur_dark  = dark[i];
      end
    end
    digit_out_d   = '0;
    sel_out_d     = idx_q;
    an_n_d        = '1;
    blank_d       = 1'b1;
    frame_start_d = 1'b0;
    if (primed_q) begin
      frame_start_d = (idx_q == '0) && (pcnt_q == '0);
      if (!cur_dark) begin
        digit_out_d = cur_digit;
        blank_d     = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
          an_n_d[i] = (idx_q != SEL_W'(i));
        end
      end
    end
  end

  // State and registered outputs; reset forces a dark display immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q        <= '0;
      idx_q         <= '0;
      snap_d_q      <= '0;
      snap_en_q     <= '0;
      primed_q      <= 1'b0;
      digit_out_q   <= '0;
      sel_out_q     <= '0;
      an_n_q        <= '1;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      idx_q         <= idx_d;
      snap_d_q      <= snap_d_d;
      snap_en_q     <= snap_en_d;
      primed_q      <= primed_d;
      digit_out_q   <= digit_out_d;
      sel_out_q     <= sel_out_d;
      an_n_q        <= an_n_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign digit_out   = digit_out_q;
  assign sel_out     = sel_out_q;
  assign an_n        = an_n_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// tb/tb_digit_scan_mux.sv - self-checking bench for digit_scan_mux (4-digit and 3-digit instances)
module tb_digit_scan_mux;

  typedef struct packed {
    logic [3:0] digit;
    logic [1:0] sel;
    logic [3:0] an;
    logic       blank;
    logic       fs;
  } obs_t;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  en;
    logic [15:0] mid;
  } vec_t;

  localparam obs_t RESET_OBS = '{digit: 4'h0, sel: 2'd0, an: 4'hF, blank: 1'b1, fs: 1'b0};

  logic        clk;
  logic        rst_n, rst_b_n;
  logic [15:0] digits_in;
  logic [3:0]  digit_en;
  logic [3:0]  a_digit;
  logic [1:0]  a_sel;
  logic [3:0]  a_an;
  logic        a_blank, a_fs;

  logic [11:0] digits_b;
  logic [2:0]  en_b;
  logic [3:0]  b_digit;
  logic [1:0]  b_sel;
  logic [2:0]  b_an;
  logic        b_blank, b_fs;

  int   n_checks;
  int   n_pass;
  vec_t tbl [10];
  obs_t sb[$];

  digit_scan_mux #(.N_DIGITS(4), .DIGIT_W(4), .PRESCALE(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .digit_en(digit_en),
    .digit_out(a_digit), .sel_out(a_sel), .an_n(a_an), .blank(a_blank), .frame_start(a_fs)
  );

  digit_scan_mux #(.N_DIGITS(3), .DIGIT_W(4), .PRESCALE(2)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .digits_in(digits_b), .digit_en(en_b),
    .digit_out(b_digit), .sel_out(b_sel), .an_n(b_an), .blank(b_blank), .frame_start(b_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t obs_a();
    obs_t o;
    o = {a_digit, a_sel, a_an, a_blank, a_fs};
    return o;
  endfunction

  function automatic logic [10:0] obs_b();
    return {b_digit, b_sel, b_an, b_blank, b_fs};
  endfunction

  function automatic obs_t exp_for(input logic [15:0] d, input logic [3:0] en, input int pos, input bit fs);
    obs_t e;
    bit   dk;
    dk = !en[pos];
`ifdef LEADING_ZERO_BLANK_EN
    if (pos != 0 && (d >> (pos * 4)) == 16'h0) dk = 1'b1;
`endif
    e.digit = dk ? 4'h0 : d[pos*4 +: 4];
    e.sel   = 2'(pos);
    e.an    = dk ? 4'hF : ~(4'b0001 << pos);
    e.blank = dk;
    e.fs    = fs;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Called at a negedge with rst_n low: releases reset, drives table frames, scoreboards outputs
  task automatic run_seq(input int first, input int cnt);
    int   n;
    obs_t e;
    vec_t v;
    sb.delete();
    rst_n = 1'b1;
    sb.push_back(RESET_OBS);
    n = 0;
    while (1) begin
      if (n > 0) begin
        e = sb.pop_front();
        check($sformatf("scan v%0d n%0d", first + (n - 2) / 16, n), obs_a(), e);
      end
      if (n % 16 == 0 && n / 16 < cnt) begin
        v = tbl[first + n / 16];
        digits_in = v.d;
        digit_en  = v.en;
        for (int c = 0; c < 16; c++)
          sb.push_back(exp_for(v.d, v.en, c / 4, c == 0));
      end
      if (n % 16 == 6 && (n - 6) / 16 < cnt)
        digits_in = tbl[first + (n - 6) / 16].mid;
      if (sb.size() == 0) break;
      if (n > 1000) begin
        check("scoreboard_drain_timeout", 32'(sb.size()), 32'd0);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [10:0] eb;
    int p;
    n_checks = 0;
    n_pass   = 0;
    tbl[0] = '{16'h1234, 4'hF, 16'h1234};
    tbl[1] = '{16'h1234, 4'hF, 16'h5678};
    tbl[2] = '{16'h5678, 4'hF, 16'h5678};
    tbl[3] = '{16'h0005, 4'hF, 16'h0005};
    tbl[4] = '{16'h0000, 4'hF, 16'h0000};
    tbl[5] = '{16'h0105, 4'hD, 16'h0105};
    tbl[6] = '{16'h00A0, 4'hF, 16'hFFFF};
    tbl[7] = '{16'h0F00, 4'h7, 16'h0F00};
    tbl[8] = '{16'h9876, 4'hF, 16'h9876};
    tbl[9] = '{16'h00C0, 4'hE, 16'h00C0};

    digits_in = 16'h1234;
    digit_en  = 4'hF;
    digits_b  = 12'h321;
    en_b      = 3'h7;
    rst_n     = 1'b1;
    rst_b_n   = 1'b1;
    #1;
    rst_n   = 1'b0;
    rst_b_n = 1'b0;
    #1;
    check("reset_async_a", obs_a(), RESET_OBS);
    check("reset_async_b", obs_b(), {4'h0, 2'd0, 3'b111, 1'b1, 1'b0});
    repeat (3) @(negedge clk);
    check("reset_held_a", obs_a(), RESET_OBS);

    run_seq(0, 8);

    repeat (9) @(negedge clk);
    check("pre_reset_idx2", obs_a(), exp_for(16'h0F00, 4'h7, 2, 1'b0));
    digits_in = 16'h9876;
    digit_en  = 4'hF;
    #2 rst_n = 1'b0;
    #1 check("midframe_reset_async", obs_a(), RESET_OBS);
    @(negedge clk);
    check("midframe_reset_held", obs_a(), RESET_OBS);

    run_seq(8, 2);

    @(negedge clk);
    check("reset_held_b", obs_b(), {4'h0, 2'd0, 3'b111, 1'b1, 1'b0});
    rst_b_n = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 1) begin
        eb = {4'h0, 2'd0, 3'b111, 1'b1, 1'b0};
      end else begin
        p  = ((n - 2) / 2) % 3;
        eb = {4'(p + 1), 2'(p), ~(3'b001 << p), 1'b0, (n - 2) % 6 == 0};
      end
      check($sformatf("npow2 n%0d", n), obs_b(), eb);
    end
    #2 rst_b_n = 1'b0;
    #1 check("npow2_reset_async", obs_b(), {4'h0, 2'd0, 3'b111, 1'b1, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
